// File: rtl/mips_pkg.sv
// Shared MIPS encodings for the ID/EX stage: opcode/funct values, ALU control
// codes, control-flag struct and operand-select enums.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_MEM  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_BEQ  = 4'b1000;
  localparam logic [3:0] ALU_JAL  = 4'b1001;
  localparam logic [3:0] ALU_JR   = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1011;

  localparam logic [4:0] LINK_REG = 5'd31;

  typedef struct packed {
    logic reg_wr;
    logic mem_rd;
    logic mem_wr;
    logic branch;
    logic jump;
    logic illegal;
  } ctrl_flags_t;

  typedef enum logic {IN1_RS, IN1_RT} in1_sel_e;
  typedef enum logic [1:0] {IN2_RT, IN2_SIMM, IN2_ZIMM, IN2_SHAMT} in2_sel_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID -> EX bus: decoded-instruction inputs from ID and registered EX outputs.
interface id_ex_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  // Valid-only flow: no ready. A transfer happens on every posedge where the
  // stage is not stalled; stall/flush come from the hazard unit, not from here.
  logic              id_valid_i;
  logic [31:0]       id_instr_i;
  logic [XLEN-1:0]   id_rs_val_i;
  logic [XLEN-1:0]   id_rt_val_i;

  logic              ex_valid_o;
  logic [XLEN-1:0]   ex_in1_o;
  logic [XLEN-1:0]   ex_in2_o;
  logic [3:0]        ex_alu_ctrl_o;
  logic [XLEN-1:0]   ex_store_o;
  logic [REG_AW-1:0] ex_dest_o;
  logic              ex_reg_wr_o;
  logic              ex_mem_rd_o;
  logic              ex_mem_wr_o;
  logic              ex_branch_o;
  logic              ex_jump_o;
  logic              ex_illegal_o;

  modport master (
    output id_valid_i, id_instr_i, id_rs_val_i, id_rt_val_i,
    input  ex_valid_o, ex_in1_o, ex_in2_o, ex_alu_ctrl_o, ex_store_o, ex_dest_o,
           ex_reg_wr_o, ex_mem_rd_o, ex_mem_wr_o, ex_branch_o, ex_jump_o, ex_illegal_o
  );

  modport slave (
    input  id_valid_i, id_instr_i, id_rs_val_i, id_rt_val_i,
    output ex_valid_o, ex_in1_o, ex_in2_o, ex_alu_ctrl_o, ex_store_o, ex_dest_o,
           ex_reg_wr_o, ex_mem_rd_o, ex_mem_wr_o, ex_branch_o, ex_jump_o, ex_illegal_o
  );
endinterface

// File: rtl/id_ex_decode.sv
// Combinational instruction decoder: ALU control, side-effect flags, operand
// selects, expanded immediate and destination register.
module id_ex_decode
  import mips_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [5:0]      op,
  input  logic [4:0]      rt_f,
  input  logic [15:0]     imm,
  output logic [3:0]      alu_ctrl,
  output ctrl_flags_t     flags,
  output in1_sel_e        in1_sel,
  output in2_sel_e        in2_sel,
  output logic [XLEN-1:0] imm_ext,
  output logic [4:0]      dest
);

  logic [4:0] rd_f;
  logic [4:0] shamt;
  logic [5:0] funct;
  logic       wants_wr;

  assign rd_f  = imm[15:11];
  assign shamt = imm[10:6];
  assign funct = imm[5:0];

  always_comb begin
    alu_ctrl = ALU_ADD;
    flags    = '0;
    in1_sel  = IN1_RS;
    in2_sel  = IN2_RT;
    dest     = 5'd0;
    wants_wr = 1'b0;
    case (op)
      OP_RTYPE: begin
        dest     = rd_f;
        wants_wr = 1'b1;
        case (funct)
          FN_ADD: alu_ctrl = ALU_ADD;
          FN_AND: alu_ctrl = ALU_AND;
          FN_NOR: alu_ctrl = ALU_NOR;
          FN_SLT: alu_ctrl = ALU_SLT;
          FN_SLL: begin
            alu_ctrl = ALU_SLL;
            in1_sel  = IN1_RT;
            in2_sel  = IN2_SHAMT;
          end
          FN_JR: begin
            alu_ctrl   = ALU_JR;
            flags.jump = 1'b1;
            wants_wr   = 1'b0;
          end
          default: begin
            flags.illegal = 1'b1;
            wants_wr      = 1'b0;
            dest          = 5'd0;
          end
        endcase
      end
      OP_ADDI: begin
        in2_sel  = IN2_SIMM;
        dest     = rt_f;
        wants_wr = 1'b1;
      end
      OP_ANDI: begin
        alu_ctrl = ALU_AND;
        in2_sel  = IN2_ZIMM;
        dest     = rt_f;
        wants_wr = 1'b1;
      end
      OP_LW: begin
        alu_ctrl     = ALU_MEM;
        in2_sel      = IN2_SIMM;
        flags.mem_rd = 1'b1;
        dest         = rt_f;
        wants_wr     = 1'b1;
      end
      OP_SW: begin
        alu_ctrl     = ALU_MEM;
        in2_sel      = IN2_SIMM;
        flags.mem_wr = 1'b1;
      end
      OP_BEQ: begin
        alu_ctrl     = ALU_BEQ;
        flags.branch = 1'b1;
      end
      OP_JAL: begin
        alu_ctrl   = ALU_JAL;
        flags.jump = 1'b1;
        dest       = LINK_REG;
        wants_wr   = 1'b1;
      end
      default: flags.illegal = 1'b1;
    endcase
    // Writes to $0 are architecturally discarded, so never request them.
    flags.reg_wr = wants_wr && (dest != 5'd0);
  end

  always_comb begin
    case (in2_sel)
      IN2_SIMM:  imm_ext = {{(XLEN-16){imm[15]}}, imm};
      IN2_ZIMM:  imm_ext = XLEN'(imm);
      IN2_SHAMT: imm_ext = XLEN'(shamt);
      default:   imm_ext = '0;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// Registered ID/EX pipeline stage feeding the ALU; stall holds, flush bubbles.
// Optional operand forwarding from EX/MEM and MEM/WB under FORWARDING_EN.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
`ifdef FORWARDING_EN
  input  logic              exmem_wr_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [XLEN-1:0]   exmem_val_i,
  input  logic              memwb_wr_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [XLEN-1:0]   memwb_val_i,
`endif
  id_ex_stage_if.slave      bus
);

  logic [3:0]      alu_ctrl;
  ctrl_flags_t     flags;
  in1_sel_e        in1_sel;
  in2_sel_e        in2_sel;
  logic [XLEN-1:0] imm_ext;
  logic [4:0]      dest;
  logic [XLEN-1:0] rs_v;
  logic [XLEN-1:0] rt_v;
  logic [XLEN-1:0] in1_n;
  logic [XLEN-1:0] in2_n;

  id_ex_decode #(.XLEN(XLEN)) u_decode (
    .op       (bus.id_instr_i[31:26]),
    .rt_f     (bus.id_instr_i[20:16]),
    .imm      (bus.id_instr_i[15:0]),
    .alu_ctrl (alu_ctrl),
    .flags    (flags),
    .in1_sel  (in1_sel),
    .in2_sel  (in2_sel),
    .imm_ext  (imm_ext),
    .dest     (dest)
  );

`ifdef FORWARDING_EN
  // EX/MEM is the younger producer, so it wins over MEM/WB; $0 never forwards.
  function automatic logic [XLEN-1:0] fwd(input logic [4:0] f, input logic [XLEN-1:0] rf);
    if (f != 5'd0 && exmem_wr_i && exmem_rd_i == REG_AW'(f))
      return exmem_val_i;
    else if (f != 5'd0 && memwb_wr_i && memwb_rd_i == REG_AW'(f))
      return memwb_val_i;
    else
      return rf;
  endfunction

  assign rs_v = fwd(bus.id_instr_i[25:21], bus.id_rs_val_i);
  assign rt_v = fwd(bus.id_instr_i[20:16], bus.id_rt_val_i);
`else
  logic [4:0] unused_rs_f;
  assign unused_rs_f = bus.id_instr_i[25:21];
  assign rs_v        = bus.id_rs_val_i;
  assign rt_v        = bus.id_rt_val_i;
`endif

  assign in1_n = (in1_sel == IN1_RT) ? rt_v : rs_v;
  assign in2_n = (in2_sel == IN2_RT) ? rt_v : imm_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ex_valid_o    <= 1'b0;
      bus.ex_in1_o      <= '0;
      bus.ex_in2_o      <= '0;
      bus.ex_alu_ctrl_o <= '0;
      bus.ex_store_o    <= '0;
      bus.ex_dest_o     <= '0;
      bus.ex_reg_wr_o   <= 1'b0;
      bus.ex_mem_rd_o   <= 1'b0;
      bus.ex_mem_wr_o   <= 1'b0;
      bus.ex_branch_o   <= 1'b0;
      bus.ex_jump_o     <= 1'b0;
      bus.ex_illegal_o  <= 1'b0;
    end else if (flush_i || (!stall_i && !bus.id_valid_i)) begin
      // Bubble: kill everything with a side effect, leave the datapath as is.
      bus.ex_valid_o    <= 1'b0;
      bus.ex_reg_wr_o   <= 1'b0;
      bus.ex_mem_rd_o   <= 1'b0;
      bus.ex_mem_wr_o   <= 1'b0;
      bus.ex_branch_o   <= 1'b0;
      bus.ex_jump_o     <= 1'b0;
      bus.ex_illegal_o  <= 1'b0;
    end else if (!stall_i) begin
      bus.ex_valid_o    <= 1'b1;
      bus.ex_in1_o      <= in1_n;
      bus.ex_in2_o      <= in2_n;
      bus.ex_alu_ctrl_o <= alu_ctrl;
      bus.ex_store_o    <= rt_v;
      bus.ex_dest_o     <= REG_AW'(dest);
      bus.ex_reg_wr_o   <= flags.reg_wr;
      bus.ex_mem_rd_o   <= flags.mem_rd;
      bus.ex_mem_wr_o   <= flags.mem_wr;
      bus.ex_branch_o   <= flags.branch;
      bus.ex_jump_o     <= flags.jump;
      bus.ex_illegal_o  <= flags.illegal;
    end
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Registered ID/EX pipeline stage directly upstream of the MIPS ALU.
- Decodes the instruction word into the ALU's 4-bit control code and selects and registers the ALU operands (in1, in2).
- Also registers the downstream control flags for the MEM/WB stages.
- Supports stall (hold), flush (bubble) and, optionally, operand forwarding.

Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register-index width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall_i  in  1  hold all output registers
- flush_i  in  1  insert bubble; wins over stall_i
- id_valid_i  in  1  id_instr_i holds a real instruction
- id_instr_i  in  32  instruction word
- id_rs_val_i  in  XLEN  register-file value of rs
- id_rt_val_i  in  XLEN  register-file value of rt
- exmem_wr_i  in  1  EX/MEM will write a register (FORWARDING_EN only)
- exmem_rd_i  in  REG_AW  EX/MEM destination (FORWARDING_EN only)
- exmem_val_i  in  XLEN  EX/MEM result (FORWARDING_EN only)
- memwb_wr_i  in  1  MEM/WB writes (FORWARDING_EN only)
- memwb_rd_i  in  REG_AW  MEM/WB destination (FORWARDING_EN only)
- memwb_val_i  in  XLEN  MEM/WB result (FORWARDING_EN only)
- ex_valid_o  out  1  EX slot holds an instruction
- ex_in1_o  out  XLEN  ALU in1
- ex_in2_o  out  XLEN  ALU in2
- ex_alu_ctrl_o  out  4  ALU control code
- ex_store_o  out  XLEN  store data (forwarded rt)
- ex_dest_o  out  REG_AW  writeback register
- ex_reg_wr_o  out  1  register write enable
- ex_mem_rd_o  out  1  load
- ex_mem_wr_o  out  1  store
- ex_branch_o  out  1  beq
- ex_jump_o  out  1  jal/jr
- ex_illegal_o  out  1  unsupported opcode/funct

Behaviour:
- Reset: all outputs 0, applied asynchronously on rst_n low. Release is synchronised by the reset tree.
- Latency: 1 cycle. All outputs are registers; no combinational path from inputs to outputs.
- Priority at each posedge is flush_i > stall_i > capture.
  - flush_i: ex_valid_o and all side-effect flags (reg_wr, mem_rd, mem_wr, branch, jump, illegal) become 0. Datapath outputs are don't-care and held.
  - stall_i: every output register holds.
  - capture with id_valid_i=0: same as flush (bubble).
- Decode of opcode[31:26] and funct[5:0]:
  - R-type 000000:
    - add 100000 -> ctrl 0000
    - and 100100 -> 0101
    - nor 100111 -> 0111
    - slt 101010 -> 1011
    - sll 000000 -> 0100; in1 = rt value, in2 = zero-extended shamt[10:6]
    - jr 001000 -> 1010; jump=1, no reg write
  - addi 001000 -> 0000, in2 = sign-extended imm
  - andi 001100 -> 0101, in2 = zero-extended imm
  - lw 100011 -> 0010, mem_rd=1, in2 = sign-extended imm
  - sw 101011 -> 0010, mem_wr=1, in2 = sign-extended imm
  - beq 000100 -> 1000, branch=1, in2 = rt value
  - jal 000011 -> 1001, jump=1, dest=31, reg_wr=1
- Default in1 = rs value. R-type in2 = rt value.
- Destination: R-type -> rd; addi/andi/lw -> rt; jal -> 31.
- ex_reg_wr_o is forced 0 when the destination is register 0.
- Illegal opcode or funct: valid=1, illegal=1, ctrl=0000, all side-effect flags 0.
- ex_store_o always carries the (possibly forwarded) rt value.

Optional Feature:
- Macro: FORWARDING_EN.
- Defined:
  - The rs and rt values are replaced before operand selection.
  - Priority is EX/MEM over MEM/WB over register file.
  - A source matches when its wr flag is 1, its rd equals the instruction's rs/rt field, and that field is nonzero.
  - Register 0 is never forwarded.
- Undefined: the forwarding ports are absent and the register-file values are used directly. Hazards are resolved upstream by stalling.

Decomposition:
- mips_pkg holds:
  - opcode constants
  - funct constants
  - ALU control code constants (0000, 0010, 0100, 0101, 0111, 1000, 1001, 1010, 1011)
  - the control-flag struct typedef
- One sub-module, id_ex_decode: combinational instruction-to-(alu_ctrl, flags, operand-select) decoder, reusable by hazard logic.

Test Plan:
- add $3,$1,$2 with rs=5, rt=7, valid=1 -> next cycle in1=5, in2=7, ctrl=0000, dest=3, reg_wr=1, valid=1.
- addi $4,$1,-1 (imm 0xFFFF) with rs=10 -> in2=0xFFFFFFFF, ctrl=0000. andi with imm 0xFFFF -> in2=0x0000FFFF, ctrl=0101.
- Capture lw, then stall_i=1 for 3 cycles with a new instruction on the inputs -> outputs unchanged. Asserting flush_i together with stall_i -> valid=0, mem_rd=0 next cycle.
- Opcode 111111 -> valid=1, illegal=1, reg_wr=0, ctrl=0000. Instruction with rd=0 -> reg_wr=0.
- FORWARDING_EN, add rs=$2 with exmem(wr=1, rd=2, val=0xAA) and memwb(wr=1, rd=2, val=0xBB) -> in1=0xAA. Same with rd=0 on both -> in1 = register-file value.
- Assert rst_n=0 mid-stream, asynchronously between clock edges -> all outputs 0 immediately and held until release.
